// File: rtl/range_updown_counter_pkg.sv
// Shared constants, operation encoding and priority decode for the range up/down counter.
package range_updown_counter_pkg;

    // Bound behaviour selected by the mode input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Direction selected by the up_dn input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Operation taken at a clock edge once reset is out of the way.
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_CFG_OK  = 3'd1,
        OP_CFG_BAD = 3'd2,
        OP_LOAD    = 3'd3,
        OP_STEP    = 3'd4
    } op_e;

    // Priority decode: cfg_we beats load beats en; losers are dropped.
    function automatic op_e decode_op(
        input logic cfg_req,
        input logic cfg_ok,
        input logic load_req,
        input logic step_req
    );
        op_e op;
        op = OP_IDLE;
        if (cfg_req) begin
            op = cfg_ok ? OP_CFG_OK : OP_CFG_BAD;
        end else if (load_req) begin
            op = OP_LOAD;
        end else if (step_req) begin
            op = OP_STEP;
        end
        return op;
    endfunction

endpackage

// File: rtl/range_next_calc.sv
// Combinational next-count and terminal-hit logic for one enabled counter step.
module range_next_calc
    import range_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             up_dn,
    input  logic             mode,
    output logic [WIDTH-1:0] next_c,
    output logic             hit_c
);

    logic at_top;
    logic at_bottom;

    // Bound compares happen before any +/-1, so the arithmetic never overflows.
    always_comb begin
        at_top    = (count >= hi);
        at_bottom = (count <= lo);
    end

    // Select the stepped value and flag a step taken from the bound in the travel direction.
    always_comb begin
        next_c = count;
        hit_c  = 1'b0;
        if (up_dn == DIR_UP) begin
            if (at_top) begin
                hit_c  = 1'b1;
                next_c = (mode == MODE_SAT) ? hi : lo;
            end else begin
                next_c = count + WIDTH'(1);
            end
        end else begin
            if (at_bottom) begin
                hit_c  = 1'b1;
                next_c = (mode == MODE_SAT) ? lo : hi;
            end else begin
                next_c = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/range_updown_counter.sv
// Up/down counter between runtime-programmable bounds with wrap/saturate, load and terminal count.
module range_updown_counter
    import range_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOW_DEF  = 3,
    parameter int unsigned HIGH_DEF = 45
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] hi_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_lo,
    output logic             at_hi,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] LO_RST = WIDTH'(LOW_DEF);
    localparam logic [WIDTH-1:0] HI_RST = WIDTH'(HIGH_DEF);

    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;

    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic             tc_nxt;
    logic             cfg_err_nxt;

    logic [WIDTH-1:0] step_val;
    logic             step_hit;
    logic [WIDTH-1:0] load_clamped;
    logic             cfg_ok;
    op_e              op;

    // Next value for an enabled step from the current count and bounds.
    range_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .count  (count),
        .lo     (lo_r),
        .hi     (hi_r),
        .up_dn  (up_dn),
        .mode   (mode),
        .next_c (step_val),
        .hit_c  (step_hit)
    );

    // Bound flags follow the registered count directly.
    assign at_lo = (count == lo_r);
    assign at_hi = (count == hi_r);

    // Load value forced into the current window; new bounds validated.
    always_comb begin
        cfg_ok = (lo_in <= hi_in);
        if (load_val < lo_r) begin
            load_clamped = lo_r;
        end else if (load_val > hi_r) begin
            load_clamped = hi_r;
        end else begin
            load_clamped = load_val;
        end
        op = decode_op(cfg_we, cfg_ok, load, en);
    end

    // Priority mux for count, bounds, terminal count and the sticky config error.
    always_comb begin
        count_nxt   = count;
        lo_nxt      = lo_r;
        hi_nxt      = hi_r;
        tc_nxt      = 1'b0;
        cfg_err_nxt = cfg_err;
        unique case (op)
            OP_CFG_OK: begin
                lo_nxt      = lo_in;
                hi_nxt      = hi_in;
                count_nxt   = lo_in;
                cfg_err_nxt = 1'b0;
            end
            OP_CFG_BAD: begin
                cfg_err_nxt = 1'b1;
            end
            OP_LOAD: begin
                count_nxt = load_clamped;
                tc_nxt    = tc;
            end
            OP_STEP: begin
                count_nxt = step_val;
                tc_nxt    = step_hit;
            end
            default: begin
                count_nxt = count;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= LO_RST;
            lo_r    <= LO_RST;
            hi_r    <= HI_RST;
            tc      <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            count   <= count_nxt;
            lo_r    <= lo_nxt;
            hi_r    <= hi_nxt;
            tc      <= tc_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_range_updown_counter.sv
// Scoreboard bench for range_updown_counter: stimulus queues expectations, a monitor checks them.
module tb_range_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       mode;
    logic       load;
    logic [7:0] load_val;
    logic       cfg_we;
    logic [7:0] lo_in;
    logic [7:0] hi_in;
    logic [7:0] count;
    logic       tc;
    logic       at_lo;
    logic       at_hi;
    logic       cfg_err;

    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        string       name;
        int unsigned tgt;
        logic [7:0]  cnt;
        logic        tc;
        logic        err;
        logic        alo;
        logic        ahi;
    } exp_t;

    exp_t sb[$];

    range_updown_counter #(
        .WIDTH    (8),
        .LOW_DEF  (3),
        .HIGH_DEF (45)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .cfg_we   (cfg_we),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .count    (count),
        .tc       (tc),
        .at_lo    (at_lo),
        .at_hi    (at_hi),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc_do(
        input string nm,
        input logic r, input logic e, input logic u, input logic m,
        input logic ld, input logic [7:0] lv,
        input logic cw, input logic [7:0] li, input logic [7:0] hv,
        input logic [7:0] ec, input logic et, input logic ee,
        input logic [7:0] elo, input logic [7:0] ehi
    );
        exp_t x;
        rst = r; en = e; up_dn = u; mode = m;
        load = ld; load_val = lv;
        cfg_we = cw; lo_in = li; hi_in = hv;
        x.name = nm;
        x.tgt  = cyc + 1;
        x.cnt  = ec;
        x.tc   = et;
        x.err  = ee;
        x.alo  = (ec == elo);
        x.ahi  = (ec == ehi);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            while (sb.size() > 0 && sb[0].tgt == cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if ({count, tc, cfg_err, at_lo, at_hi} !== {e.cnt, e.tc, e.err, e.alo, e.ahi}) begin
                    n_fail++;
                    $display("FAIL %s: got count=%0d tc=%b err=%b at_lo=%b at_hi=%b, want count=%0d tc=%b err=%b at_lo=%b at_hi=%b",
                             e.name, count, tc, cfg_err, at_lo, at_hi, e.cnt, e.tc, e.err, e.alo, e.ahi);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 1'b0; load = 1'b0;
        load_val = 8'd0; cfg_we = 1'b0; lo_in = 8'd0; hi_in = 8'd0;
        @(posedge clk);
        #1;

        // 1: reset, then count up with wrap through 45 -> 3
        cyc_do("reset",       0, 0, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 0, 0, 8'd3, 8'd45);
        for (int v = 4; v <= 45; v++) begin
            cyc_do("up_wrap", 1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'(v), 0, 0, 8'd3, 8'd45);
        end
        cyc_do("wrap_45_3",   1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 1, 0, 8'd3, 8'd45);
        cyc_do("after_wrap",  1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd4, 0, 0, 8'd3, 8'd45);

        // 2: reset, down saturate at lo, then turn upward
        cyc_do("reset2",      0, 0, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 0, 0, 8'd3, 8'd45);
        for (int i = 0; i < 3; i++) begin
            cyc_do("dn_sat",  1, 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 1, 0, 8'd3, 8'd45);
        end
        cyc_do("sat_to_up",   1, 1, 1, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd4, 0, 0, 8'd3, 8'd45);
        cyc_do("dn_4_3",      1, 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 0, 0, 8'd3, 8'd45);
        cyc_do("dn_wrap_3_45",1, 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd45, 1, 0, 8'd3, 8'd45);
        cyc_do("dn_45_44",    1, 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd44, 0, 0, 8'd3, 8'd45);
        cyc_do("en_off_hold", 1, 0, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd44, 0, 0, 8'd3, 8'd45);

        // 3: new bounds 10..12, wrap, then a rejected config
        cyc_do("cfg_10_12",   1, 0, 1, 0, 0, 8'd0, 1, 8'd10, 8'd12, 8'd10, 0, 0, 8'd10, 8'd12);
        cyc_do("up_11",       1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd11, 0, 0, 8'd10, 8'd12);
        cyc_do("up_12",       1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd12, 0, 0, 8'd10, 8'd12);
        cyc_do("wrap_12_10",  1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd10, 1, 0, 8'd10, 8'd12);
        cyc_do("cfg_bad",     1, 0, 1, 0, 0, 8'd0, 1, 8'd20, 8'd5, 8'd10, 0, 1, 8'd10, 8'd12);
        cyc_do("err_sticky",  1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd11, 0, 1, 8'd10, 8'd12);

        // 4: load with clamping; load keeps tc
        cyc_do("load_200",    1, 0, 1, 0, 1, 8'd200, 0, 8'd0, 8'd0, 8'd12, 0, 1, 8'd10, 8'd12);
        cyc_do("load_0",      1, 0, 1, 0, 1, 8'd0,   0, 8'd0, 8'd0, 8'd10, 0, 1, 8'd10, 8'd12);
        cyc_do("load_11",     1, 0, 1, 0, 1, 8'd11,  0, 8'd0, 8'd0, 8'd11, 0, 1, 8'd10, 8'd12);
        cyc_do("up_12b",      1, 1, 1, 0, 0, 8'd0,   0, 8'd0, 8'd0, 8'd12, 0, 1, 8'd10, 8'd12);
        cyc_do("wrap_tc",     1, 1, 1, 0, 0, 8'd0,   0, 8'd0, 8'd0, 8'd10, 1, 1, 8'd10, 8'd12);
        cyc_do("load_keeps_tc",1,1, 1, 0, 1, 8'd11,  0, 8'd0, 8'd0, 8'd11, 1, 1, 8'd10, 8'd12);

        // 5: cfg beats load and en; then reset mid-count clears cfg_err
        cyc_do("cfg_wins",    1, 1, 1, 0, 1, 8'd35, 1, 8'd30, 8'd40, 8'd30, 0, 0, 8'd30, 8'd40);
        cyc_do("up_31",       1, 1, 1, 0, 0, 8'd0,  0, 8'd0,  8'd0,  8'd31, 0, 0, 8'd30, 8'd40);
        cyc_do("load_beats_en",1,1, 1, 0, 1, 8'd38, 0, 8'd0,  8'd0,  8'd38, 0, 0, 8'd30, 8'd40);
        cyc_do("cfg_bad2",    1, 1, 1, 0, 0, 8'd0,  1, 8'd9,  8'd2,  8'd38, 0, 1, 8'd30, 8'd40);
        cyc_do("rst_mid",     0, 1, 1, 0, 1, 8'd20, 1, 8'd50, 8'd60, 8'd3,  0, 0, 8'd3,  8'd45);

        // 6: degenerate window lo == hi == 7
        cyc_do("cfg_7_7",     1, 1, 1, 0, 0, 8'd0, 1, 8'd7, 8'd7, 8'd7, 0, 0, 8'd7, 8'd7);
        for (int i = 0; i < 3; i++) begin
            cyc_do("eq_up",   1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd7, 1, 0, 8'd7, 8'd7);
        end
        cyc_do("eq_dn_sat",   1, 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd7, 1, 0, 8'd7, 8'd7);
        cyc_do("eq_idle",     1, 0, 0, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd7, 0, 0, 8'd7, 8'd7);

        en = 1'b0; load = 1'b0; cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
